// File: rtl/flap_input_conditioner_pkg.sv
// Shared types and constants for the flap push-button conditioner.
package flap_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } flap_state_t;

    localparam int FLAP_CNT_W = 8;

    // Width that holds any value up to the larger of the two cycle counts.
    function automatic int cnt_width(input int debounce_cycles, input int repeat_cycles);
        int largest;
        largest = (debounce_cycles > repeat_cycles) ? debounce_cycles : repeat_cycles;
        return $clog2(largest) + 1;
    endfunction

endpackage

// File: rtl/flap_input_conditioner_if.sv
// Bus between the flap conditioner and its environment: raw key and enable in, clean controls out.
interface flap_input_conditioner_if;
    import flap_pkg::*;

    logic                  key_n;
    logic                  enable;
    logic                  flap;
    logic                  held;
    logic [FLAP_CNT_W-1:0] flap_count;

    modport master (output key_n, output enable, input flap, input held, input flap_count);
    modport slave  (input key_n, input enable, output flap, output held, output flap_count);

endinterface

// File: rtl/flap_input_conditioner_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/flap_input_conditioner.sv
// Debounces the active-low flap key and emits one registered flap pulse per accepted press.
// Optional auto-repeat while the key is held is built when FLAP_AUTOREPEAT_EN is defined.
module flap_input_conditioner
    import flap_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    flap_input_conditioner_if.slave  bus
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES, REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                  key_pressed;
    logic                  btn_s;
    flap_state_t           state;
    flap_state_t           next_state;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic                  accept;
    logic                  issue;
    logic                  flap_r;
    logic                  held_r;
    logic [FLAP_CNT_W-1:0] count_r;

    assign key_pressed = ~bus.key_n;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (key_pressed),
        .q     (btn_s)
    );

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            RELEASED: begin
                if (btn_s) begin
                    next_state = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    next_state = RELEASED;
                end else if (cnt == DEB_LAST) begin
                    next_state = PRESSED;
                    accept     = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    next_state = RELEASE_WAIT;
                    cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                // A key that comes back during the release window is a bounce, not a new press.
                if (btn_s) begin
                    next_state = PRESSED;
                end else if (cnt == DEB_LAST) begin
                    next_state = RELEASED;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                next_state = RELEASED;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef FLAP_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] rep_next;
    logic             repeat_fire;

    // The repeat counter only advances while steadily pressed; a release bounce pauses it.
    always_comb begin
        rep_next    = rep_cnt;
        repeat_fire = 1'b0;
        if (accept) begin
            rep_next = '0;
        end else if (state == PRESSED && btn_s) begin
            if (rep_cnt == REP_LAST) begin
                repeat_fire = 1'b1;
                rep_next    = '0;
            end else begin
                rep_next = rep_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_next;
        end
    end

    assign issue = accept | repeat_fire;
`else
    assign issue = accept;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RELEASED;
            cnt     <= '0;
            flap_r  <= 1'b0;
            held_r  <= 1'b0;
            count_r <= '0;
        end else begin
            state   <= next_state;
            cnt     <= cnt_next;
            flap_r  <= issue & bus.enable;
            held_r  <= (next_state == PRESSED) || (next_state == RELEASE_WAIT);
            if (issue && bus.enable) begin
                count_r <= count_r + FLAP_CNT_W'(1);
            end
        end
    end

    assign bus.flap       = flap_r;
    assign bus.held       = held_r;
    assign bus.flap_count = count_r;

endmodule

// File: tb/tb_flap_input_conditioner.sv
// Self-checking bench for flap_input_conditioner: directed table, corner sequences, random key traffic.
module tb_flap_input_conditioner;
    import flap_pkg::*;

    localparam int DEB    = 16;
    localparam int REP    = 64;
    localparam int PERIOD = 100;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    flap_input_conditioner_if bus ();

    flap_input_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #(PERIOD/2) clk = ~clk;

    // Reference: debounced level flips after DEB+1 consecutive synchronised samples that disagree with it.
    typedef struct {
        logic [1:0] sync;
        bit         level;
        int         run;
        int         rep;
        logic       flap;
        logic       held;
        logic [7:0] count;
    } model_t;

    model_t m;

    function automatic model_t model_step(model_t cur, logic key_n, logic en);
        model_t nx    = cur;
        bit     s     = cur.sync[1];
        bit     issue = 1'b0;
        nx.sync = {cur.sync[0], ~key_n};
        if (s != cur.level) begin
            nx.run = cur.run + 1;
            if (nx.run == DEB + 1) begin
                nx.level = ~cur.level;
                nx.run   = 0;
                if (nx.level) begin
                    issue  = 1'b1;
                    nx.rep = 0;
                end
            end
        end else begin
`ifdef FLAP_AUTOREPEAT_EN
            if (cur.level && cur.run == 0) begin
                if (cur.rep == REP - 1) begin
                    issue  = 1'b1;
                    nx.rep = 0;
                end else begin
                    nx.rep = cur.rep + 1;
                end
            end
`endif
            nx.run = 0;
        end
        nx.flap = issue && en;
        nx.held = nx.level;
        if (nx.flap) nx.count = cur.count + 8'd1;
        return nx;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '{default: 0};
        else       m <= model_step(m, bus.key_n, bus.enable);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            checkOutput("model_flap", 32'(bus.flap), 32'(m.flap));
            checkOutput("model_held", 32'(bus.held), 32'(m.held));
            checkOutput("model_count", 32'(bus.flap_count), 32'(m.count));
        end
    end

    // Drives one segment and counts flap pulses seen after each of the following edges.
    task automatic applyStimulus(input logic key_n, input logic en, input int cycles, output int flaps);
        flaps      = 0;
        bus.key_n  = key_n;
        bus.enable = en;
        repeat (cycles) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.flap === 1'b1) flaps++;
        end
    endtask

    typedef struct {
        logic  key_n;
        int    cycles;
        logic  enable;
        int    exp_flaps;
        logic  exp_held;
        string name;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #(PERIOD * 50000);
        $display("[TB] FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int f;
        int first_flap;
        int first_held;
        logic [7:0] start_count;

        vecs[0]  = '{1'b1, 10, 1'b1, 0, 1'b0, "idle"};
        vecs[1]  = '{1'b0, 40, 1'b1, 1, 1'b1, "press"};
        vecs[2]  = '{1'b1,  4, 1'b1, 0, 1'b1, "release_bounce_hi"};
        vecs[3]  = '{1'b0, 10, 1'b1, 0, 1'b1, "release_bounce_lo"};
        vecs[4]  = '{1'b1, 30, 1'b1, 0, 1'b0, "release"};
        vecs[5]  = '{1'b0,  5, 1'b1, 0, 1'b0, "bounce_lo1"};
        vecs[6]  = '{1'b1,  3, 1'b1, 0, 1'b0, "bounce_hi"};
        vecs[7]  = '{1'b0,  5, 1'b1, 0, 1'b0, "bounce_lo2"};
        vecs[8]  = '{1'b1, 30, 1'b1, 0, 1'b0, "bounce_end"};
        vecs[9]  = '{1'b0, 40, 1'b0, 0, 1'b1, "disabled_press"};
        vecs[10] = '{1'b1, 30, 1'b0, 0, 1'b0, "disabled_release"};
        vecs[11] = '{1'b0, 30, 1'b0, 0, 1'b1, "press_before_enable"};
        vecs[12] = '{1'b0, 10, 1'b1, 0, 1'b1, "enable_while_pressed"};
        vecs[13] = '{1'b1, 30, 1'b1, 0, 1'b0, "final_release"};

        bus.key_n  = 1'b1;
        bus.enable = 1'b1;
        reset      = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_flap", 32'(bus.flap), 32'd0);
        checkOutput("reset_held", 32'(bus.held), 32'd0);
        checkOutput("reset_count", 32'(bus.flap_count), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].key_n, vecs[i].enable, vecs[i].cycles, f);
            checkOutput({vecs[i].name, "_flaps"}, 32'(f), 32'(vecs[i].exp_flaps));
            checkOutput({vecs[i].name, "_held"}, 32'(bus.held), 32'(vecs[i].exp_held));
        end
        checkOutput("table_count", 32'(bus.flap_count), 32'd1);

        // Latency: edge index 0 is the first edge that samples key_n low.
        first_flap = -1;
        first_held = -1;
        bus.key_n  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.flap === 1'b1 && first_flap < 0) first_flap = i;
            if (bus.held === 1'b1 && first_held < 0) first_held = i;
        end
        checkOutput("latency_flap", 32'(first_flap), 32'(DEB + 2));
        checkOutput("latency_held", 32'(first_held), 32'(DEB + 2));
        checkOutput("latency_count", 32'(bus.flap_count), 32'd2);

        // Asynchronous reset between edges while the key is still pressed.
        #10;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_flap", 32'(bus.flap), 32'd0);
        checkOutput("async_reset_held", 32'(bus.held), 32'd0);
        checkOutput("async_reset_count", 32'(bus.flap_count), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 30, f);
        checkOutput("repress_after_reset_flaps", 32'(f), 32'd1);
        checkOutput("repress_after_reset_count", 32'(bus.flap_count), 32'd1);
        applyStimulus(1'b1, 1'b1, 30, f);

`ifdef FLAP_AUTOREPEAT_EN
        applyStimulus(1'b0, 1'b1, 200, f);
        checkOutput("autorepeat_flaps", 32'(f), 32'd3);
        applyStimulus(1'b1, 1'b1, 30, f);
`endif

        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                          int'($urandom_range(1, 40)), f);
        end
        applyStimulus(1'b1, 1'b1, 30, f);

        start_count = bus.flap_count;
        first_flap  = 0;
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b0, 1'b1, 20, f);
            first_flap += f;
            applyStimulus(1'b1, 1'b1, 20, f);
        end
        checkOutput("wrap_flaps", 32'(first_flap), 32'd256);
        checkOutput("wrap_count", 32'(bus.flap_count), 32'(start_count));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
